alu_result_uart_tx: RTL
=======================

// Module: alu_result_uart_tx
// PURPOSE
//  Output side of the ALU board path: captures one ALU result word plus zero/carry flags and serializes them on a UART TX line as two 8N1 frames.
//  Sits after the ALU/operand-load stage; drives the board's FTDI TX pin so results can be read on a host instead of LEDs.
// PARAMETERS
//  NB_DATA        8    ALU result width; must be 8 (one frame per field)
//  CLKS_PER_BIT   868  clk cycles per UART bit (100 MHz / 115200); >= 2
// PORTS
//  clk        in   1        system clock; all state on rising edge
//  i_rst      in   1        reset, asynchronous, active-high
//  i_valid    in   1        request: capture result/flags this cycle
//  i_result   in   NB_DATA  ALU result
//  i_zero     in   1        ALU zero flag
//  i_carry    in   1        ALU carry flag
//  o_ready    out  1        block idle, will accept i_valid
//  o_busy     out  1        transmission in progress (= ~o_ready)
//  o_done     out  1        1-cycle pulse: last stop bit complete
//  o_tx       out  1        UART serial line, idle high
// BEHAVIOUR
//  Reset: o_tx=1, o_ready=1, o_busy=0, o_done=0, FSM=IDLE, counters=0; async assert, takes effect mid-frame with line forced high.
//  Handshake: capture on rising edge with i_valid&&o_ready; byte0=i_result, byte1={6'b0,i_zero,i_carry}. i_valid while busy ignored, not queued.
//  FSM: IDLE -> START -> DATA(8 bits, LSB first) -> [PARITY] -> STOP -> (byte0 ? START of byte1 : IDLE).
//  o_tx is registered; start bit appears on o_tx in the cycle after the capture edge; each bit held exactly CLKS_PER_BIT cycles.
//  Baud counter counts 0..CLKS_PER_BIT-1, reloads to 0 on every bit change; bit index 0..7; byte select 0..1.
//  No idle gap between byte0 stop and byte1 start.
//  Total busy time: 20*CLKS_PER_BIT cycles (22* with parity).
//  On final cycle of byte1 stop: next edge FSM=IDLE, o_ready=1, o_done=1 for that one cycle only.
//  i_valid asserted in the o_done cycle is accepted (back-to-back transfers, one-cycle idle line minimum).
//  Inputs not sampled outside the capture edge; changes during transmission have no effect.
// CONFIGURATION
//  ALU_RESULT_TX_PARITY_EN defined: PARITY state inserted after DATA, even parity over the 8 data bits, frame 8E1 (11 bits).
//  Undefined: no PARITY state, frame 8N1 (10 bits); parity logic absent from netlist.
// STRUCTURE
//  Shared package/header alu_uart_pkg: FSM state encodings (IDLE,START,DATA,PARITY,STOP), UART_START_BIT=1'b0, UART_STOP_BIT=1'b1, NB_FRAME_DATA=8.
//  Sub-module uart_tx_byte: one-frame serializer (baud counter, bit index, shift reg, start/done); top holds capture regs, byte sequencing, handshake.
//  Counter widths via $clog2(CLKS_PER_BIT).
// TESTING  (bench CLKS_PER_BIT=4)
//  1 Reset: assert i_rst mid-idle -> o_tx=1, o_ready=1, o_done=0 same cycle, no edges needed.
//  2 i_result=8'hA5, zero=0, carry=1, i_valid 1 cycle -> o_tx: 0,1,0,1,0,0,1,0,1,1 then 0,1,0,0,0,0,0,0,0,1, 4 cycles/bit; o_done after 80 cycles.
//  3 i_valid held high throughout transfer with changing i_result -> only first value sent; second transfer starts in o_done cycle.
//  4 i_rst asserted at byte0 bit 3 -> o_tx=1 immediately, o_ready=1; new i_valid 8'h3C transmitted cleanly.
//  5 i_result=8'h00, zero=1, carry=0 -> byte1 frame 0,0,1,0,0,0,0,0,0,1; stop-bit monitor sees no framing error.
//  6 ALU_RESULT_TX_PARITY_EN, 8'h07 -> parity bit 1 after data; byte1 8'h02 -> parity 1; o_done after 88 cycles.

Source files
------------

// File: rtl/alu_uart_pkg.sv
// Shared UART framing constants and TX state encoding for the ALU result path.
// Optional even-parity framing is selected with ALU_RESULT_TX_PARITY_EN.
package alu_uart_pkg;

    localparam int   NB_FRAME_DATA  = 8;
    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    function automatic logic even_parity(input logic [NB_FRAME_DATA-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// One-frame UART serializer: start, 8 data bits LSB first, optional parity, stop.
// A start request on the final stop cycle chains the next frame with no idle gap.
//
//   state  | meaning
//   IDLE   | line high, waiting for start
//   START  | driving start bit
//   DATA   | shifting out 8 data bits, LSB first
//   PARITY | even parity bit (ALU_RESULT_TX_PARITY_EN builds only)
//   STOP   | driving stop bit; last cycle may reload the next frame
module uart_tx_byte
    import alu_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                     clk,
    input  logic                     i_rst,
    input  logic                     start,
    input  logic [NB_FRAME_DATA-1:0] data,
    output logic                     tx,
    output logic                     last
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t                state;
    logic [CNT_W-1:0]         baud_cnt;
    logic [2:0]               bit_idx;
    logic [NB_FRAME_DATA-1:0] shreg;
    logic                     bit_end;
`ifdef ALU_RESULT_TX_PARITY_EN
    logic                     parity;
`endif

    assign bit_end = (baud_cnt == BAUD_LAST);
    assign last    = (state == STOP) && bit_end;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx       <= UART_STOP_BIT;
`ifdef ALU_RESULT_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            if (state != IDLE)
                baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg <= data;
                        tx    <= UART_START_BIT;
                        state <= START;
`ifdef ALU_RESULT_TX_PARITY_EN
                        parity <= even_parity(data);
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx      <= shreg[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
`ifdef ALU_RESULT_TX_PARITY_EN
                            tx    <= parity;
                            state <= PARITY;
`else
                            tx    <= UART_STOP_BIT;
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                        end
                    end
                end
`ifdef ALU_RESULT_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        tx    <= UART_STOP_BIT;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        if (start) begin
                            shreg <= data;
                            tx    <= UART_START_BIT;
                            state <= START;
`ifdef ALU_RESULT_TX_PARITY_EN
                            parity <= even_parity(data);
`endif
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    tx    <= UART_STOP_BIT;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_result_uart_tx.sv
// Captures an ALU result plus zero/carry flags and sends them as two UART frames.
// Define ALU_RESULT_TX_PARITY_EN for 8E1 framing; default build is 8N1.
module alu_result_uart_tx
    import alu_uart_pkg::*;
#(
    parameter int NB_DATA      = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_result,
    input  logic               i_zero,
    input  logic               i_carry,
    output logic               o_ready,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_tx
);

    logic                     accept;
    logic                     byte_sel;
    logic [NB_FRAME_DATA-1:0] flags_byte;
    logic                     tx_start;
    logic                     tx_last;
    logic [NB_FRAME_DATA-1:0] tx_data;

    assign accept   = i_valid && o_ready;
    assign o_busy   = ~o_ready;
    // Byte0 goes straight from the input port; byte1 chains on byte0's last stop cycle.
    assign tx_start = accept || (tx_last && !byte_sel);
    assign tx_data  = o_ready ? NB_FRAME_DATA'(i_result) : flags_byte;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            o_ready    <= 1'b1;
            o_done     <= 1'b0;
            byte_sel   <= 1'b0;
            flags_byte <= '0;
        end else begin
            o_done <= 1'b0;
            if (accept) begin
                o_ready    <= 1'b0;
                byte_sel   <= 1'b0;
                flags_byte <= {6'b0, i_zero, i_carry};
            end else if (tx_last) begin
                if (!byte_sel) begin
                    byte_sel <= 1'b1;
                end else begin
                    byte_sel <= 1'b0;
                    o_ready  <= 1'b1;
                    o_done   <= 1'b1;
                end
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk   (clk),
        .i_rst (i_rst),
        .start (tx_start),
        .data  (tx_data),
        .tx    (o_tx),
        .last  (tx_last)
    );

endmodule
